// File: rtl/clkdiv_prog_if.sv
// Bus bundle for clkdiv_prog: enable, configuration write port and divider outputs.
interface clkdiv_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic             clkout;
    logic [CNT_W-1:0] cnt;
    logic             cfg_pend;
    logic             rise_stb;
    logic             fall_stb;

    modport master (
        output en, cfg_we, cfg_period, cfg_high,
        input  clkout, cnt, cfg_pend, rise_stb, fall_stb
    );

    modport slave (
        input  en, cfg_we, cfg_period, cfg_high,
        output clkout, cnt, cfg_pend, rise_stb, fall_stb
    );
endinterface

// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider with double-buffered period/high-time settings.
// Edge strobes are present only when CLKDIV_STB_EN is defined; otherwise tied to 0.
module clkdiv_prog #(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 26,
    parameter int DEF_HIGH   = 14
) (
    input  logic           clk,
    input  logic           rst,
    clkdiv_prog_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEF_PER_C = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_HI_C  = CNT_W'(DEF_HIGH);

    // Period P = max(N,1)+1, kept one bit wider so N = all-ones does not wrap.
    function automatic logic [CNT_W:0] period_of(input logic [CNT_W-1:0] n);
        if (n == '0) return (CNT_W+1)'(2);
        return {1'b0, n} + (CNT_W+1)'(1);
    endfunction

    function automatic logic level_at(input logic [CNT_W-1:0] k,
                                      input logic [CNT_W-1:0] n,
                                      input logic [CNT_W-1:0] h);
        logic [CNT_W:0] p;
        logic [CNT_W:0] hx;
        p  = period_of(n);
        hx = {1'b0, h};
        if (hx >= p) return 1'b1;
        return {1'b0, k} >= (p - hx);
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_a_q, per_a_d;
    logic [CNT_W-1:0] hi_a_q, hi_a_d;
    logic [CNT_W-1:0] per_p_q, per_p_d;
    logic [CNT_W-1:0] hi_p_q, hi_p_d;
    logic             pend_q, pend_d;
    logic             clkout_q, clkout_d;
    logic             at_end;
    logic             wrap;

    always_comb begin
        per_a_d  = per_a_q;
        hi_a_d   = hi_a_q;
        per_p_d  = per_p_q;
        hi_p_d   = hi_p_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        clkout_d = clkout_q;
        at_end   = ({1'b0, cnt_q} == (period_of(per_a_q) - (CNT_W+1)'(1)));
        wrap     = bus.en && at_end;

        if (bus.cfg_we) begin
            per_p_d = bus.cfg_period;
            hi_p_d  = bus.cfg_high;
            pend_d  = 1'b1;
        end

        if (wrap) begin
            cnt_d = '0;
            // A write landing on the wrap cycle bypasses the pending registers.
            if (bus.cfg_we) begin
                per_a_d = bus.cfg_period;
                hi_a_d  = bus.cfg_high;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                per_a_d = per_p_q;
                hi_a_d  = hi_p_q;
                pend_d  = 1'b0;
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (bus.en) clkout_d = level_at(cnt_d, per_a_d, hi_a_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            per_a_q  <= DEF_PER_C;
            hi_a_q   <= DEF_HI_C;
            per_p_q  <= '0;
            hi_p_q   <= '0;
            pend_q   <= 1'b0;
            clkout_q <= level_at('0, DEF_PER_C, DEF_HI_C);
        end else begin
            cnt_q    <= cnt_d;
            per_a_q  <= per_a_d;
            hi_a_q   <= hi_a_d;
            per_p_q  <= per_p_d;
            hi_p_q   <= hi_p_d;
            pend_q   <= pend_d;
            clkout_q <= clkout_d;
        end
    end

    assign bus.clkout   = clkout_q;
    assign bus.cnt      = cnt_q;
    assign bus.cfg_pend = pend_q;

`ifdef CLKDIV_STB_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Strobes drop to 0 once en is sampled low; the pre-pause value stays visible for that cycle.
    always_comb begin
        rise_d = bus.en &&  clkout_d && !clkout_q;
        fall_d = bus.en && !clkout_d &&  clkout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.rise_stb = rise_q;
    assign bus.fall_stb = fall_q;
`else
    assign bus.rise_stb = 1'b0;
    assign bus.fall_stb = 1'b0;
`endif
endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed self-checking bench for clkdiv_prog: vector table plus hand sequences.
module tb_clkdiv_prog;
    localparam int CNT_W = 8;
`ifdef CLKDIV_STB_EN
    localparam bit STB = 1'b1;
`else
    localparam bit STB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdiv_prog_if #(.CNT_W(CNT_W)) bus ();

    clkdiv_prog #(.CNT_W(CNT_W), .DEF_PERIOD(26), .DEF_HIGH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit       en;
        bit       we;
        bit [7:0] per;
        bit [7:0] hi;
        int       cnt;
        bit       clk_o;
        bit       pend;
        bit       rise;
        bit       fall;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(bit en, bit we, bit [7:0] per, bit [7:0] hi,
                                int c, bit co, bit p, bit r, bit f);
        vec_t v;
        v.en = en; v.we = we; v.per = per; v.hi = hi;
        v.cnt = c; v.clk_o = co; v.pend = p; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit co, input bit p,
                           input bit r, input bit f);
        check({tag, ".cnt"},      int'(bus.cnt),      c);
        check({tag, ".clkout"},   int'(bus.clkout),   int'(co));
        check({tag, ".cfg_pend"}, int'(bus.cfg_pend), int'(p));
        check({tag, ".rise_stb"}, int'(bus.rise_stb), int'(r & STB));
        check({tag, ".fall_stb"}, int'(bus.fall_stb), int'(f & STB));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;

        // Table continues from cnt=26 of the default period with N=3,H=2 pending.
        add(1,0,0,0, 0,0,0,0,1); add(1,0,0,0, 1,0,0,0,0); add(1,0,0,0, 2,1,0,1,0);
        add(1,0,0,0, 3,1,0,0,0); add(1,0,0,0, 0,0,0,0,1); add(1,0,0,0, 1,0,0,0,0);
        add(1,0,0,0, 2,1,0,1,0); add(1,0,0,0, 3,1,0,0,0);
        add(1,1,1,1, 0,0,0,0,1); add(1,0,0,0, 1,1,0,1,0); add(1,0,0,0, 0,0,0,0,1);
        add(1,0,0,0, 1,1,0,1,0);
        add(1,1,4,0, 0,0,0,0,1); add(1,0,0,0, 1,0,0,0,0); add(1,0,0,0, 2,0,0,0,0);
        add(1,0,0,0, 3,0,0,0,0); add(1,0,0,0, 4,0,0,0,0); add(1,0,0,0, 0,0,0,0,0);
        add(1,1,4,9, 1,0,1,0,0); add(1,0,0,0, 2,0,1,0,0); add(1,0,0,0, 3,0,1,0,0);
        add(1,0,0,0, 4,0,1,0,0); add(1,0,0,0, 0,1,0,1,0); add(1,0,0,0, 1,1,0,0,0);
        add(1,0,0,0, 2,1,0,0,0); add(1,0,0,0, 3,1,0,0,0); add(1,0,0,0, 4,1,0,0,0);
        add(1,0,0,0, 0,1,0,0,0);
        add(1,1,0,1, 1,1,1,0,0); add(1,0,0,0, 2,1,1,0,0); add(1,0,0,0, 3,1,1,0,0);
        add(1,0,0,0, 4,1,1,0,0); add(1,0,0,0, 0,0,0,0,1); add(1,0,0,0, 1,1,0,1,0);
        add(1,0,0,0, 0,0,0,0,1); add(1,0,0,0, 1,1,0,1,0);

        // Reset state
        rst = 1'b1; step(); step();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0; bus.en = 1'b1;

        // Two default periods: 27 cycles, high for cnt 13..26
        for (int i = 1; i <= 54; i++) begin
            step();
            chk_all("default", i % 27, (i % 27) >= 13, 0, (i % 27) == 13, (i % 27) == 0);
        end
        for (int i = 1; i <= 5; i++) step();
        check("pre_write.cnt", int'(bus.cnt), 5);
        bus.cfg_we = 1'b1; bus.cfg_period = 8'd3; bus.cfg_high = 8'd2;
        step();
        bus.cfg_we = 1'b0;
        chk_all("pend_set", 6, 0, 1, 0, 0);
        for (int k = 7; k <= 26; k++) begin
            step();
            chk_all("pend_wait", k, k >= 13, 1, k == 13, 0);
        end

        foreach (vecs[i]) begin
            bus.en = vecs[i].en; bus.cfg_we = vecs[i].we;
            bus.cfg_period = vecs[i].per; bus.cfg_high = vecs[i].hi;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].clk_o, vecs[i].pend,
                    vecs[i].rise, vecs[i].fall);
        end
        bus.cfg_we = 1'b0;

        // Enable pause at cnt=10 with a write pending
        rst = 1'b1; bus.en = 1'b0; step();
        rst = 1'b0; bus.en = 1'b1;
        for (int i = 1; i <= 3; i++) step();
        bus.cfg_we = 1'b1; bus.cfg_period = 8'd5; bus.cfg_high = 8'd3;
        step();
        bus.cfg_we = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        chk_all("pause_entry", 10, 0, 1, 0, 0);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("paused", 10, 0, 1, 0, 0);
        end
        bus.en = 1'b1;
        for (int k = 11; k <= 26; k++) begin
            step();
            chk_all("resume", k, k >= 13, 1, k == 13, 0);
        end
        step(); chk_all("apply_after_pause", 0, 0, 0, 0, 1);
        step(); chk_all("n5h3_c1", 1, 0, 0, 0, 0);
        step(); chk_all("n5h3_c2", 2, 0, 0, 0, 0);
        step(); chk_all("n5h3_c3", 3, 1, 0, 1, 0);
        bus.en = 1'b0;
        step(); chk_all("pause_high", 3, 1, 0, 0, 0);
        bus.en = 1'b1;

        // Reset at cnt=20 with a pending write, coincident with en and cfg_we
        rst = 1'b1; step();
        rst = 1'b0; step(); step();
        bus.cfg_we = 1'b1; bus.cfg_period = 8'd3; bus.cfg_high = 8'd1;
        step();
        bus.cfg_we = 1'b0;
        for (int k = 4; k <= 20; k++) step();
        chk_all("pre_reset", 20, 1, 1, 0, 0);
        rst = 1'b1; bus.cfg_we = 1'b1;
        step();
        chk_all("mid_reset", 0, 0, 0, 0, 0);
        rst = 1'b0; bus.cfg_we = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            step();
            chk_all("restored", i % 27, (i % 27) >= 13, 0, (i % 27) == 13, (i % 27) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
